// File: rtl/example_a_chan_scheduler_pkg.sv
// Shared types and constants for the A-channel scheduler: opcode/beat types,
// the transaction record carried through the pipeline, and byte extraction.
package example_a_chan_scheduler_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [1:0] beat_t;

  localparam int BEATS = 4;

  typedef struct packed {
    opcode_t     op;
    logic [31:0] data;
  } txn_t;

  // Beat k of a payload is byte k, least significant byte first.
  function automatic logic [7:0] beat_byte(logic [31:0] data, beat_t k);
    return data[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/example_a_chan_scheduler_if.sv
// Requester handshake plus folded A-channel outputs; the scheduler is the master
// (drives ready and the channel), the sequencer side is the slave.
interface example_a_chan_scheduler_if
  import example_a_chan_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*4-1:0]  req_opcode;
  logic [NUM_REQ*32-1:0] req_data;

  logic                  valid_00H;
  opcode_t               opcode_01H;
  beat_t                 beat_0nH;
  logic [7:0]            data_0nH;

  modport master (
    input  req_valid, req_opcode, req_data,
    output req_ready, valid_00H, opcode_01H, beat_0nH, data_0nH
  );

  modport slave (
    output req_valid, req_opcode, req_data,
    input  req_ready, valid_00H, opcode_01H, beat_0nH, data_0nH
  );

endinterface

// File: rtl/example_a_chan_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping to index 0; produces a one-hot grant and its binary index.
module example_a_chan_scheduler_rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] at_or_after;
  logic [N-1:0] all_req;
  logic [N-1:0] hi_req;
  logic [N-1:0] sel;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign at_or_after[gi] = (gi >= int'(ptr_i));
  end

  assign all_req = en_i ? req_i : '0;
  assign hi_req  = all_req & at_or_after;
  // Prefer requests at/after the pointer; otherwise wrap to the lowest index.
  assign sel     = (|hi_req) ? hi_req : all_req;
  assign grant_o = sel & (~sel + N'(1));

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_o[i]) idx_o = idx_o | W'(i);
    end
  end

endmodule

// File: rtl/example_a_chan_scheduler.sv
// Round-robin scheduler that serializes requester transactions onto the folded
// A-channel: valid, then opcode, then four payload beats, one txn per BEATS cycles.
module example_a_chan_scheduler
  import example_a_chan_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  example_a_chan_scheduler_if.master    bus,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               slot_open;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  txn_t               req_txn;

  // Issue stage holds the txn during its valid cycle; beat stage walks its bytes.
  txn_t               iss_q;
  logic               iss_vld_q;
  txn_t               bt_q;
  logic               bt_vld_q;
  beat_t              bt_age_q;

  logic               valid_q;
  opcode_t            op_q;
  beat_t              beat_q;
  logic [7:0]         data_q;
  logic               busy_q;

  assign slot_open = (slot_cnt_q == '0) && en && !rst;

  example_a_chan_scheduler_rr_arbiter #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_arb (
    .req_i   (bus.req_valid),
    .en_i    (slot_open),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign bus.req_ready = grant;
  assign accept        = |(grant & bus.req_valid);

  always_comb begin
    req_txn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        req_txn.op   = bus.req_opcode[i*4 +: 4];
        req_txn.data = bus.req_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    if (accept)                slot_cnt_d = CNT_W'(BEATS - 1);
    else if (slot_cnt_q != '0) slot_cnt_d = slot_cnt_q - 1'b1;
    else                       slot_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      ptr_q      <= '0;
      iss_q      <= '0;
      iss_vld_q  <= 1'b0;
      bt_q       <= '0;
      bt_vld_q   <= 1'b0;
      bt_age_q   <= '0;
      valid_q    <= 1'b0;
      op_q       <= '0;
      beat_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      ptr_q      <= ptr_d;
      iss_vld_q  <= accept;
      if (accept) iss_q <= req_txn;

      // Handoff into the beat stage coincides with the previous txn's last beat.
      if (iss_vld_q) begin
        bt_q     <= iss_q;
        bt_vld_q <= 1'b1;
        bt_age_q <= '0;
      end else if (bt_vld_q) begin
        bt_age_q <= bt_age_q + 1'b1;
        if (bt_age_q == beat_t'(BEATS - 1)) bt_vld_q <= 1'b0;
      end

      valid_q <= accept;
      op_q    <= iss_vld_q ? iss_q.op : '0;
      beat_q  <= bt_vld_q ? bt_age_q : '0;
      data_q  <= bt_vld_q ? beat_byte(bt_q.data, bt_age_q) : '0;
      busy_q  <= accept | iss_vld_q | bt_vld_q;
    end
  end

  assign bus.valid_00H  = valid_q;
  assign bus.opcode_01H = op_q;
  assign bus.beat_0nH   = beat_q;
  assign bus.data_0nH   = data_q;
  assign busy           = busy_q;

endmodule
